// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared widths and redirect FSM state type for the 5-stage MIPS
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int ADDR_W = 32;
  localparam int JIDX_W = 26;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } redir_state_t;

endpackage

`default_nettype wire

// File: rtl/branch_target_gen.sv
// ============================================================================
// branch_target_gen : taken decision and redirect target for the EX instruction
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_target_gen
  import mips_pkg::*;
(
  input  logic              i_ex_valid,
  input  logic              i_ex_beq,
  input  logic              i_ex_bne,
  input  logic              i_ex_jump,
  input  logic              i_ex_zero,
  input  logic [ADDR_W-1:0] i_ex_after_pc,
  input  logic [ADDR_W-1:0] i_ex_imm,
  input  logic [JIDX_W-1:0] i_ex_jidx,
  output logic              o_taken,
  output logic [ADDR_W-1:0] o_target
);

  logic [ADDR_W-1:0] w_imm_words;
  logic [ADDR_W-1:0] w_branch_target;
  logic [ADDR_W-1:0] w_jump_target;

  // Branch offset is in words; the add wraps silently modulo 2^32.
  assign w_imm_words     = i_ex_imm << 2;
  assign w_branch_target = i_ex_after_pc + w_imm_words;
  assign w_jump_target   = {i_ex_after_pc[ADDR_W-1 -: 4], i_ex_jidx, 2'b00};

  always_comb begin
    o_taken  = i_ex_valid & (i_ex_jump | (i_ex_beq & i_ex_zero) | (i_ex_bne & ~i_ex_zero));
    o_target = i_ex_jump ? w_jump_target : w_branch_target;
  end

endmodule

`default_nettype wire

// File: rtl/branch_redirect_unit.sv
// ============================================================================
// branch_redirect_unit : registers EX-stage branch/jump decisions and drives
//                        the one-cycle fetch redirect plus wrong-path flushes
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_redirect_unit
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_beq,
  input  logic              ex_bne,
  input  logic              ex_jump,
  input  logic              ex_zero,
  input  logic [ADDR_W-1:0] ex_after_pc,
  input  logic [ADDR_W-1:0] ex_imm,
  input  logic [JIDX_W-1:0] ex_jidx,
  output logic              PCSrc,
  output logic [ADDR_W-1:0] target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic              w_taken;
  logic [ADDR_W-1:0] w_next_target;

  redir_state_t      r_state;
  logic              r_pcsrc;
  logic              r_flush;
  logic [ADDR_W-1:0] r_target;
  logic [CNT_W-1:0]  r_taken_cnt;

  branch_target_gen u_target_gen (
    .i_ex_valid    (ex_valid),
    .i_ex_beq      (ex_beq),
    .i_ex_bne      (ex_bne),
    .i_ex_jump     (ex_jump),
    .i_ex_zero     (ex_zero),
    .i_ex_after_pc (ex_after_pc),
    .i_ex_imm      (ex_imm),
    .i_ex_jidx     (ex_jidx),
    .o_taken       (w_taken),
    .o_target      (w_next_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pcsrc     <= 1'b0;
      r_flush     <= 1'b0;
      r_target    <= '0;
      r_taken_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_taken) begin
            r_state  <= REDIRECT;
            r_pcsrc  <= 1'b1;
            r_flush  <= 1'b1;
            r_target <= w_next_target;
            if (r_taken_cnt != C_CNT_MAX) begin
              r_taken_cnt <= r_taken_cnt + C_CNT_ONE;
            end
          end else begin
            r_pcsrc <= 1'b0;
            r_flush <= 1'b0;
          end
        end
        // EX holds a wrong-path instruction here, so its inputs are ignored.
        REDIRECT: begin
          r_state <= IDLE;
          r_pcsrc <= 1'b0;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_pcsrc <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign PCSrc        = r_pcsrc;
  assign target       = r_target;
  assign flush_if_id  = r_flush;
  assign flush_id_ex  = r_flush;
  assign flush_ex_mem = r_flush;
  assign taken_cnt    = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
// ============================================================================
// tb_branch_redirect_unit : directed + random checks of branch_redirect_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_beq, ex_bne, ex_jump, ex_zero;
  logic [31:0] ex_after_pc, ex_imm;
  logic [25:0] ex_jidx;

  logic        pcsrc_a, pcsrc_b;
  logic [31:0] target_a, target_b;
  logic        fif_a, fid_a, fex_a, fif_b, fid_b, fex_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what IF should see after each edge.
  bit          m_redirect;
  logic [31:0] m_target;
  int          m_cnt16, m_cnt2;

  always #5 clk = ~clk;

  branch_redirect_unit #(.CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_beq(ex_beq), .ex_bne(ex_bne),
    .ex_jump(ex_jump), .ex_zero(ex_zero), .ex_after_pc(ex_after_pc), .ex_imm(ex_imm),
    .ex_jidx(ex_jidx), .PCSrc(pcsrc_a), .target(target_a), .flush_if_id(fif_a),
    .flush_id_ex(fid_a), .flush_ex_mem(fex_a), .taken_cnt(cnt_a)
  );

  branch_redirect_unit #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_beq(ex_beq), .ex_bne(ex_bne),
    .ex_jump(ex_jump), .ex_zero(ex_zero), .ex_after_pc(ex_after_pc), .ex_imm(ex_imm),
    .ex_jidx(ex_jidx), .PCSrc(pcsrc_b), .target(target_b), .flush_if_id(fif_b),
    .flush_id_ex(fid_b), .flush_ex_mem(fex_b), .taken_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit beq, input bit bne, input bit j, input bit z,
                       input logic [31:0] apc, input logic [31:0] imm, input logic [25:0] jidx);
    ex_valid = v; ex_beq = beq; ex_bne = bne; ex_jump = j; ex_zero = z;
    ex_after_pc = apc; ex_imm = imm; ex_jidx = jidx;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
  endtask

  // One clock: update the reference from the inputs seen at the edge, then compare.
  task automatic tick();
    bit          is_taken;
    logic [31:0] dest;
    @(posedge clk);
    is_taken = ex_valid && (ex_jump || (ex_beq && ex_zero) || (ex_bne && !ex_zero));
    if (ex_jump) dest = (ex_after_pc & 32'hF000_0000) | (32'(ex_jidx) * 32'd4);
    else         dest = ex_after_pc + ex_imm * 32'd4;
    if (rst) begin
      m_redirect = 0; m_target = 32'h0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (m_redirect) begin
      m_redirect = 0;  // this EX instruction was on the wrong path
    end else if (is_taken) begin
      m_redirect = 1;
      m_target   = dest;
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    #1;
    check("pcsrc",      {31'b0, pcsrc_a}, {31'b0, m_redirect});
    check("target",     target_a, m_target);
    check("flush_if_id",  {31'b0, fif_a}, {31'b0, m_redirect});
    check("flush_id_ex",  {31'b0, fid_a}, {31'b0, m_redirect});
    check("flush_ex_mem", {31'b0, fex_a}, {31'b0, m_redirect});
    check("taken_cnt",  {16'b0, cnt_a}, 32'(m_cnt16));
    check("pcsrc_w2",   {31'b0, pcsrc_b}, {31'b0, m_redirect});
    check("target_w2",  target_b, m_target);
    check("flush_w2",   {29'b0, fif_b, fid_b, fex_b}, {29'b0, {3{m_redirect}}});
    check("taken_cnt_w2", {30'b0, cnt_b}, 32'(m_cnt2));
  endtask

  initial begin
    m_redirect = 0; m_target = 32'h0; m_cnt16 = 0; m_cnt2 = 0;

    // Reset held with a jump presented
    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 32'h1234_5678, 32'h0, 26'h3FF_FFFF);
    tick(); tick();
    check("rst_pcsrc",  {31'b0, pcsrc_a}, 32'h0);
    check("rst_target", target_a, 32'h0);
    check("rst_cnt",    {16'b0, cnt_a}, 32'h0);
    rst = 1'b0;
    idle(); tick();

    // beq taken
    drive(1, 1, 0, 0, 1, 32'h0000_0010, 32'h0000_0003, 26'h0);
    tick();
    check("beq_pcsrc",  {31'b0, pcsrc_a}, 32'h1);
    check("beq_target", target_a, 32'h0000_001C);
    check("beq_cnt",    {16'b0, cnt_a}, 32'h1);
    idle(); tick();
    check("beq_pulse_end", {31'b0, pcsrc_a}, 32'h0);
    check("beq_target_hold", target_a, 32'h0000_001C);

    // bne both polarities
    drive(1, 0, 1, 0, 1, 32'h0000_0020, 32'hFFFF_FFFE, 26'h0);
    tick();
    check("bne_z1_pcsrc", {31'b0, pcsrc_a}, 32'h0);
    drive(1, 0, 1, 0, 0, 32'h0000_0020, 32'hFFFF_FFFE, 26'h0);
    tick();
    check("bne_target", target_a, 32'h0000_0018);
    idle(); tick();

    // jump has priority over beq
    drive(1, 1, 0, 1, 0, 32'hA000_0004, 32'h0000_0010, 26'h0000040);
    tick();
    check("jump_target", target_a, 32'hA000_0100);
    idle(); tick();

    // back-to-back taken branches: one redirect
    drive(1, 1, 0, 0, 1, 32'h0000_0100, 32'h0000_0004, 26'h0);
    tick();
    check("b2b_first", {31'b0, pcsrc_a}, 32'h1);
    drive(1, 1, 0, 0, 1, 32'h0000_0200, 32'h0000_0008, 26'h0);
    tick();
    check("b2b_second", {31'b0, pcsrc_a}, 32'h0);
    check("b2b_cnt",    {16'b0, cnt_a}, 32'h4);
    check("b2b_target", target_a, 32'h0000_0110);
    idle(); tick();

    // target wrap-around
    drive(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0001, 26'h0);
    tick();
    check("wrap_target", target_a, 32'h0000_0000);
    check("wrap_pcsrc",  {31'b0, pcsrc_a}, 32'h1);
    idle(); tick();

    // reset during REDIRECT
    drive(1, 0, 0, 1, 0, 32'h4000_0000, 32'h0, 26'h0000123);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_pcsrc", {31'b0, pcsrc_a}, 32'h0);
    check("rst_mid_cnt",   {16'b0, cnt_a}, 32'h0);
    rst = 1'b0;
    idle(); tick();

    // saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 0, 32'h1000_0000, 32'h0, 26'(i + 1));
      tick();
      idle(); tick();
    end
    check("sat_cnt_w2", {30'b0, cnt_b}, 32'h3);
    check("sat_cnt_w16", {16'b0, cnt_a}, 32'h5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 1) == 1) ? 32'($signed(16'($urandom))) : $urandom,
            26'($urandom));
      tick();
    end
    rst = 1'b0;
    idle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
